control_unit_pipe: RTL

- Registered successor to the ID-stage combinational decoder for the RV32IM pipeline.
- Decodes opcode, funct3 and funct7 into the full control bundle and drives it into the ID/EX register boundary with a valid bit.
- Honours downstream stall and flush requests.
- Contains an M-extension sequencer that stalls issue while a multi-cycle MUL or DIV occupies EX.

---
 rtl/control_unit_pipe.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/control_unit_pipe.sv
// rtl/control_unit_pipe.sv - registered RV32IM ID-stage decoder with M-extension issue sequencer
// Optional feature macro: CU_ILLEGAL_DETECT_EN (illegal instruction detection and pulse)
module control_unit_pipe #(
  parameter int MUL_LATENCY = 1,
  parameter int DIV_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       instr_valid,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       stall_in,
  input  logic       flush_in,
  output logic [2:0] imm_sel,
  output logic [4:0] aluop,
  output logic [2:0] branch_jump,
  output logic [2:0] funct3_out,
  output logic       op1_sel,
  output logic       op2_sel,
  output logic [1:0] mem_write,
  output logic [1:0] mem_read,
  output logic [1:0] reg_write_select,
  output logic       reg_write_enable,
  output logic       ctrl_valid,
  output logic       md_stall,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Busy counts are latency minus one: the issuing cycle itself is the first EX cycle
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic       w_known, w_illegal, w_legal, w_accept, w_issue;
  logic       w_is_md, w_multi;
  logic [CNT_W-1:0] w_lat_m1;
  logic [2:0] w_imm, w_bj;
  logic [4:0] w_alu;
  logic       w_op1, w_op2, w_we;
  logic [1:0] w_mw, w_mr, w_wrs;

  logic [2:0] r_imm, r_bj, r_f3;
  logic [4:0] r_alu;
  logic       r_op1, r_op2, r_we, r_valid, r_illegal;
  logic [1:0] r_mw, r_mr, r_wrs;

  // Opcode-level decode into the control bundle; unknown opcodes flag w_known=0
  always_comb begin
    w_known = 1'b1;
    w_imm   = 3'd0;
    w_alu   = 5'd0;
    w_bj    = 3'd0;
    w_op1   = 1'b1;
    w_op2   = 1'b0;
    w_mw    = 2'd0;
    w_mr    = 2'd0;
    w_wrs   = 2'd0;
    w_we    = 1'b0;
    case (opcode)
      OP_R:      begin w_alu = {funct7[5], funct7[0], funct3}; w_we = 1'b1; end
      OP_I:      begin w_imm = 3'd1; w_alu = {(funct3 == 3'b101) & funct7[5], 1'b0, funct3};
                       w_op2 = 1'b1; w_we = 1'b1; end
      OP_LOAD:   begin w_imm = 3'd1; w_op2 = 1'b1; w_mr = funct3[1:0] + 2'd1;
                       w_wrs = 2'd1; w_we = 1'b1; end
      OP_STORE:  begin w_imm = 3'd2; w_op2 = 1'b1; w_mw = funct3[1:0] + 2'd1; end
      OP_BRANCH: begin w_imm = 3'd3; w_alu = 5'b01000; w_bj = 3'd1; end
      OP_JAL:    begin w_op1 = 1'b0; w_imm = 3'd5; w_op2 = 1'b1; w_bj = 3'd2;
                       w_wrs = 2'd2; w_we = 1'b1; end
      OP_JALR:   begin w_imm = 3'd1; w_op2 = 1'b1; w_bj = 3'd3; w_wrs = 2'd2; w_we = 1'b1; end
      OP_LUI:    begin w_imm = 3'd4; w_wrs = 2'd3; w_we = 1'b1; end
      OP_AUIPC:  begin w_op1 = 1'b0; w_imm = 3'd4; w_op2 = 1'b1; w_we = 1'b1; end
      default:   w_known = 1'b0;
    endcase
  end

`ifdef CU_ILLEGAL_DETECT_EN
  logic w_bad;
  // Field-level encodings that are reserved even though the opcode is known
  always_comb begin
    w_bad = 1'b0;
    case (opcode)
      OP_R: begin
        if (!(funct7 inside {7'b0000000, 7'b0100000, 7'b0000001}))
          w_bad = 1'b1;
        else if ((funct7 == 7'b0100000) && !(funct3 inside {3'b000, 3'b101}))
          w_bad = 1'b1;
      end
      OP_LOAD:   w_bad = funct3 inside {3'b011, 3'b110, 3'b111};
      OP_STORE:  w_bad = (funct3 >= 3'b011);
      OP_BRANCH: w_bad = funct3 inside {3'b010, 3'b011};
      OP_JALR:   w_bad = (funct3 != 3'b000);
      default:   w_bad = 1'b0;
    endcase
  end
  assign w_legal   = w_known & ~w_bad;
  assign w_illegal = ~w_legal;
`else
  assign w_legal   = w_known;
  assign w_illegal = 1'b0;
`endif

  assign w_accept = instr_valid & ~stall_in & ~md_stall & ~flush_in;
  assign w_issue  = w_accept & w_legal;
  assign w_is_md  = (opcode == OP_R) && (funct7 == 7'b0000001);
  assign w_lat_m1 = funct3[2] ? DIV_CNT : MUL_CNT;
  assign w_multi  = (w_lat_m1 != '0);

  // Sequencer state and busy counter; stall freezes both, reset wins over everything
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: enter BUSY on a multi-cycle M op, leave after the last busy cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!stall_in) begin
      case (r_state)
        S_IDLE: if (w_issue && w_is_md && w_multi) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = w_lat_m1;
        end
        S_BUSY: if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM output: hold upstream while the M unit is occupied
  always_comb begin
    md_stall = (r_state == S_BUSY);
  end

  // ID/EX bundle register: issue, bubble, or hold under stall
  always_ff @(posedge CLK) begin
    if (RESET || (!stall_in && !w_issue)) begin
      r_imm     <= 3'd0;
      r_alu     <= 5'd0;
      r_bj      <= 3'd0;
      r_f3      <= 3'd0;
      r_op1     <= 1'b1;
      r_op2     <= 1'b0;
      r_mw      <= 2'd0;
      r_mr      <= 2'd0;
      r_wrs     <= 2'd0;
      r_we      <= 1'b0;
      r_valid   <= 1'b0;
      r_illegal <= ~RESET & w_accept & w_illegal;
    end else if (!stall_in) begin
      r_imm     <= w_imm;
      r_alu     <= w_alu;
      r_bj      <= w_bj;
      r_f3      <= funct3;
      r_op1     <= w_op1;
      r_op2     <= w_op2;
      r_mw      <= w_mw;
      r_mr      <= w_mr;
      r_wrs     <= w_wrs;
      r_we      <= w_we;
      r_valid   <= 1'b1;
      r_illegal <= 1'b0;
    end
  end

  assign imm_sel          = r_imm;
  assign aluop            = r_alu;
  assign branch_jump      = r_bj;
  assign funct3_out       = r_f3;
  assign op1_sel          = r_op1;
  assign op2_sel          = r_op2;
  assign mem_write        = r_mw;
  assign mem_read         = r_mr;
  assign reg_write_select = r_wrs;
  assign reg_write_enable = r_we;
  assign ctrl_valid       = r_valid;
  assign illegal_instr    = r_illegal;

endmodule
